// File: rtl/wfa_reduce_ctrl_if.sv
// Handshake bundle shared by wfa_reduce_ctrl, the WFA compute engine and the reduction unit.
// master = controller side, slave = engine / reduction-unit side.
interface wfa_reduce_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int REF_LEN_WIDTH = 8
);

  // Engine -> controller: finished wavefront
  logic                         step_valid;
  logic                         step_ready;
  logic signed [DATA_WIDTH-1:0] step_kmin;
  logic signed [DATA_WIDTH-1:0] step_kmax;

  // Controller <-> reduction unit
  logic                         red_start;
  logic signed [DATA_WIDTH-1:0] red_kmin;
  logic signed [DATA_WIDTH-1:0] red_kmax;
  logic [REF_LEN_WIDTH-1:0]     red_threshold;
  logic signed [DATA_WIDTH-1:0] red_kmin_new;
  logic signed [DATA_WIDTH-1:0] red_kmax_new;
  logic                         red_done;

  // Controller -> engine: bounds for the next score step
  logic                         upd_valid;
  logic                         upd_ready;
  logic signed [DATA_WIDTH-1:0] upd_kmin;
  logic signed [DATA_WIDTH-1:0] upd_kmax;
  logic                         upd_reduced;

  modport master (
    input  step_valid, step_kmin, step_kmax,
    output step_ready,
    output red_start, red_kmin, red_kmax, red_threshold,
    input  red_kmin_new, red_kmax_new, red_done,
    output upd_valid, upd_kmin, upd_kmax, upd_reduced,
    input  upd_ready
  );

  modport slave (
    output step_valid, step_kmin, step_kmax,
    input  step_ready,
    input  red_start, red_kmin, red_kmax, red_threshold,
    output red_kmin_new, red_kmax_new, red_done,
    input  upd_valid, upd_kmin, upd_kmax, upd_reduced,
    output upd_ready
  );

endinterface

// File: rtl/wfa_reduce_ctrl.sv
// Wavefront reduction sequencer: decides per score step whether to reduce, runs the reduction
// unit, validates its bounds and returns Kmin/Kmax. Optional WAIT watchdog: WFA_REDUCE_TIMEOUT_EN.
module wfa_reduce_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int REF_LEN_WIDTH  = 8,
  parameter int INTERVAL_WIDTH = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_en_i,
  input  logic [INTERVAL_WIDTH-1:0] cfg_interval_i,
  input  logic [DATA_WIDTH-1:0]     cfg_min_diags_i,
  input  logic [REF_LEN_WIDTH-1:0]  cfg_threshold_i,
  wfa_reduce_ctrl_if.master         bus,
  output logic [CNT_WIDTH-1:0]      reduce_count_o,
  output logic                      bad_result_o,
  output logic                      timeout_err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_UPDATE
  } state_e;

  state_e                       state_q,       state_d;
  logic [INTERVAL_WIDTH-1:0]    step_cnt_q,    step_cnt_d;
  logic signed [DATA_WIDTH-1:0] kmin_q,        kmin_d;
  logic signed [DATA_WIDTH-1:0] kmax_q,        kmax_d;
  logic [REF_LEN_WIDTH-1:0]     thr_q,         thr_d;
  logic signed [DATA_WIDTH-1:0] new_kmin_q,    new_kmin_d;
  logic signed [DATA_WIDTH-1:0] new_kmax_q,    new_kmax_d;
  logic signed [DATA_WIDTH-1:0] upd_kmin_q,    upd_kmin_d;
  logic signed [DATA_WIDTH-1:0] upd_kmax_q,    upd_kmax_d;
  logic                         upd_reduced_q, upd_reduced_d;
  logic [CNT_WIDTH-1:0]         count_q,       count_d;
  logic                         bad_q,         bad_d;

  logic [INTERVAL_WIDTH:0]      cnt_plus1;
  logic [INTERVAL_WIDTH:0]      interval_eff;
  logic [INTERVAL_WIDTH-1:0]    cnt_sat;
  logic signed [DATA_WIDTH:0]   num_diag;
  logic signed [DATA_WIDTH:0]   min_diags;
  logic                         take_reduce;
  logic                         result_ok;

  // The latched step bounds double as the bounds presented to the reduction unit.
  assign cnt_plus1    = {1'b0, step_cnt_q} + (INTERVAL_WIDTH+1)'(1);
  assign cnt_sat      = (&step_cnt_q) ? step_cnt_q : cnt_plus1[INTERVAL_WIDTH-1:0];
  assign interval_eff = (cfg_interval_i == '0) ? (INTERVAL_WIDTH+1)'(1) : {1'b0, cfg_interval_i};
  assign num_diag     = {kmax_q[DATA_WIDTH-1], kmax_q} - {kmin_q[DATA_WIDTH-1], kmin_q}
                        + (DATA_WIDTH+1)'(1);
  assign min_diags    = {1'b0, cfg_min_diags_i};
  assign take_reduce  = cfg_en_i && (cnt_plus1 >= interval_eff) && (num_diag >= min_diags);
  assign result_ok    = (kmin_q <= new_kmin_q) && (new_kmin_q <= new_kmax_q)
                        && (new_kmax_q <= kmax_q);

`ifdef WFA_REDUCE_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              to_q,       to_d;
  logic              wait_expired;

  // Last WAIT cycle of the budget; a red_done in that same cycle still wins.
  assign wait_expired = (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      to_q       <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      to_q       <= to_d;
    end
  end

  assign timeout_err_o = to_q;
`else
  // Without the watchdog the flag is constant; TIMEOUT_CYCLES has no effect.
  assign timeout_err_o = (TIMEOUT_CYCLES < 0);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      step_cnt_q    <= '0;
      kmin_q        <= '0;
      kmax_q        <= '0;
      thr_q         <= '0;
      new_kmin_q    <= '0;
      new_kmax_q    <= '0;
      upd_kmin_q    <= '0;
      upd_kmax_q    <= '0;
      upd_reduced_q <= 1'b0;
      count_q       <= '0;
      bad_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_cnt_q    <= step_cnt_d;
      kmin_q        <= kmin_d;
      kmax_q        <= kmax_d;
      thr_q         <= thr_d;
      new_kmin_q    <= new_kmin_d;
      new_kmax_q    <= new_kmax_d;
      upd_kmin_q    <= upd_kmin_d;
      upd_kmax_q    <= upd_kmax_d;
      upd_reduced_q <= upd_reduced_d;
      count_q       <= count_d;
      bad_q         <= bad_d;
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    step_cnt_d    = step_cnt_q;
    kmin_d        = kmin_q;
    kmax_d        = kmax_q;
    thr_d         = thr_q;
    new_kmin_d    = new_kmin_q;
    new_kmax_d    = new_kmax_q;
    upd_kmin_d    = upd_kmin_q;
    upd_kmax_d    = upd_kmax_q;
    upd_reduced_d = upd_reduced_q;
    count_d       = count_q;
    bad_d         = bad_q;
`ifdef WFA_REDUCE_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    to_d          = to_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.step_valid) begin
          kmin_d  = bus.step_kmin;
          kmax_d  = bus.step_kmax;
          thr_d   = cfg_threshold_i;
          state_d = S_DECIDE;
        end
      end

      S_DECIDE: begin
        if (take_reduce) begin
          step_cnt_d = '0;
          state_d    = S_LAUNCH;
        end else begin
          // Counter stays saturated so the next eligible step reduces.
          step_cnt_d    = cnt_sat;
          upd_kmin_d    = kmin_q;
          upd_kmax_d    = kmax_q;
          upd_reduced_d = 1'b0;
          state_d       = S_UPDATE;
        end
      end

      S_LAUNCH: begin
`ifdef WFA_REDUCE_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.red_done) begin
          new_kmin_d = bus.red_kmin_new;
          new_kmax_d = bus.red_kmax_new;
          state_d    = S_CHECK;
        end
`ifdef WFA_REDUCE_TIMEOUT_EN
        else if (wait_expired) begin
          to_d          = 1'b1;
          upd_kmin_d    = kmin_q;
          upd_kmax_d    = kmax_q;
          upd_reduced_d = 1'b0;
          state_d       = S_UPDATE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
`endif
      end

      S_CHECK: begin
        if (result_ok) begin
          upd_kmin_d    = new_kmin_q;
          upd_kmax_d    = new_kmax_q;
          upd_reduced_d = 1'b1;
          if (count_q != '1) begin
            count_d = count_q + CNT_WIDTH'(1);
          end
        end else begin
          upd_kmin_d    = kmin_q;
          upd_kmax_d    = kmax_q;
          upd_reduced_d = 1'b0;
          bad_d         = 1'b1;
        end
        state_d = S_UPDATE;
      end

      S_UPDATE: begin
        if (bus.upd_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.step_ready    = (state_q == S_IDLE);
  assign bus.red_start     = (state_q == S_LAUNCH);
  assign bus.red_kmin      = kmin_q;
  assign bus.red_kmax      = kmax_q;
  assign bus.red_threshold = thr_q;
  assign bus.upd_valid     = (state_q == S_UPDATE);
  assign bus.upd_kmin      = upd_kmin_q;
  assign bus.upd_kmax      = upd_kmax_q;
  assign bus.upd_reduced   = upd_reduced_q;
  assign reduce_count_o    = count_q;
  assign bad_result_o      = bad_q;

endmodule
